// File: rtl/franken_bus_pkg.sv
// Shared types and helpers for the franken_riscv memory bus arbiter.
package franken_bus_pkg;

    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational grant picker: first set request at or after ptr, ascending with wrap.
// A pointer tied to zero turns this into lowest-index-wins fixed priority.
module arb_grant #(
    parameter int NUM_MASTERS = 2,
    localparam int IDX_W = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       idx,
    output logic                   any
);

    always_comb begin : pick
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = |req;
        // Walk from the farthest slot back to ptr so the closest request wins last.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_MASTERS;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter, one outstanding transaction, registered outputs.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (master 0 highest); default is round-robin.
module bus_arbiter
    import franken_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEFAULT_W,
    parameter int DATA_W      = DEFAULT_W,
    localparam int BE_W       = be_width(DATA_W),
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_be,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          s_valid,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [BE_W-1:0]               s_be,
    input  logic                          s_busy,
    input  logic [DATA_W-1:0]             s_rdata
);

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] gnt, gnt_q;
    logic [IDX_W-1:0]       gnt_idx, ptr;
    logic                   gnt_any;

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDX_W-1:0] gnt_idx_q, ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            if (state == IDLE && gnt_any)
                gnt_idx_q <= gnt_idx;
            if (state == RESP)
                ptr_q <= (gnt_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;
        end
    end

    assign ptr = ptr_q;
`endif

    arb_grant #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_grant (
        .req(m_valid),
        .ptr(ptr),
        .gnt(gnt),
        .idx(gnt_idx),
        .any(gnt_any)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (!s_busy) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are computed one cycle ahead so they line up with ISSUE and RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q   <= '0;
            m_ready <= '0;
            m_rdata <= '0;
            s_valid <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_be    <= '0;
        end else begin
            s_valid <= 1'b0;
            m_ready <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gnt_q   <= gnt;
                        s_valid <= 1'b1;
                        s_we    <= m_we[gnt_idx];
                        s_addr  <= m_addr[gnt_idx*ADDR_W +: ADDR_W];
                        s_wdata <= m_wdata[gnt_idx*DATA_W +: DATA_W];
                        s_be    <= m_be[gnt_idx*BE_W +: BE_W];
                    end
                end
                WAIT: begin
                    if (!s_busy) begin
                        m_rdata <= s_rdata;
                        m_ready <= gnt_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised N-master, single-slave memory bus arbiter that sits between the franken_riscv CPU ports (instruction fetch, data load/store, later a DMA engine) and the shared dma/SPI-flash/IO slave. It replaces the hard-wired `mem_write ? alu_result : pc` address mux with a registered valid/ready handshake that respects slave wait states (flash `rbusy`). Exactly one transaction is outstanding at a time. Grants use round-robin or fixed priority.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting ports (≥2, ≤8); master 0 = fetch, master 1 = data
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); BE_W = DATA_W/8

Ports (clock is `clk`; reset is `reset`, synchronous, active-high):
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- m_valid  in  NUM_MASTERS  per-master request
- m_we  in  NUM_MASTERS  per-master write enable
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data
- m_be  in  NUM_MASTERS*BE_W  packed byte enables
- m_ready  out  NUM_MASTERS  one-cycle completion pulse, one-hot or zero
- m_rdata  out  DATA_W  registered read data, shared by all masters
- s_valid  out  1  one-cycle request strobe to slave
- s_we  out  1  slave write enable
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_be  out  BE_W  slave byte enables
- s_busy  in  1  slave wait state; high = transaction not finished
- s_rdata  in  DATA_W  slave read data, valid when s_busy low in WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any m_valid, pick grant g, latch g plus m_we/m_addr/m_wdata/m_be of g into s_* registers, go ISSUE. No request: stay.
- ISSUE: s_valid=1 for exactly this cycle; go WAIT.
- WAIT: on first cycle with s_busy=0, capture s_rdata into m_rdata (reads and writes alike), go RESP; else stay. No timeout.
- RESP: m_ready[g]=1 for exactly this cycle; update round-robin pointer to g+1 (mod NUM_MASTERS); go IDLE.
- Round-robin: search starts at pointer, ascending with wrap; first set m_valid wins.
- Master rule: hold m_valid and payload stable until m_ready; drop m_valid the cycle after m_ready unless issuing a new request. Payload change while pending is ignored (latched in IDLE).
- s_* payload held stable from ISSUE through RESP; s_valid is low in every other state.
- m_rdata holds its value until the next WAIT capture.
- Simultaneous requests: exactly one granted; others wait, are never dropped.
- Reset in any state: state=IDLE, pointer=0, all outputs 0 (m_ready, m_rdata, s_valid, s_we, s_addr, s_wdata, s_be). An in-flight slave transaction is abandoned; the slave must tolerate this.

## Timing
- Request seen at edge of cycle t (IDLE) → s_valid in t+1 → WAIT in t+2 → m_ready in t+3 if s_busy=0 in t+2. Minimum latency 3 cycles, throughput 1 transaction per 4 cycles.
- Each s_busy-high cycle in WAIT adds one cycle of latency.
- s_busy is ignored outside WAIT.
- All outputs registered; no combinational path from m_* or s_busy to any output.

## Configuration
- `BUS_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins (master 0 = fetch highest); the pointer is not implemented.
- Undefined (default): round-robin as described.

## Structure
- Package `franken_bus_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), BE_W derivation function, and the default widths constant.
- Sub-module `arb_grant`: purely combinational request vector plus pointer to one-hot grant and index, parametrised by NUM_MASTERS. The same sub-module covers both modes (pointer tied to 0 under the macro).

## Test plan
- Single read: m0 valid, addr 0x0000_0010, s_busy=0, s_rdata=0xDEAD_BEEF → s_valid at t+1 with s_addr=0x10, s_we=0; m_ready=2'b01 at t+3; m_rdata=0xDEAD_BEEF.
- Wait states: m1 write addr 0x8000_0004, wdata 0x1234_5678, be=4'b0011, s_busy high 5 WAIT cycles → m_ready[1] at t+8; s_* stable throughout, s_valid high one cycle only.
- Contention (round-robin): m0 and m1 request continuously for 4 transactions → grant order 0,1,0,1. Under `BUS_ARB_FIXED_PRIO_EN` with NUM_MASTERS=2, expect 0,0,0,0 while m0 stays valid.
- Wrap with NUM_MASTERS=4: pointer at 3, requests on m1 and m3 → m3 granted, then m1.
- Reset mid-WAIT: reset asserted while s_busy=1 → next cycle all outputs 0, state IDLE; a new m0 request afterwards completes in 3 cycles.
- Payload change: m0 changes m_addr from 0x20 to 0x40 during WAIT → s_addr stays 0x20 until RESP.
